// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - request/result bundle between the datapath and the iterative divider
interface div_iter_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] lz_in;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;

    modport master (
        output start, is_signed, dividend, divisor, lz_in,
        input  quotient, remainder, busy, done
    );

    modport slave (
        input  start, is_signed, dividend, divisor, lz_in,
        output quotient, remainder, busy, done
    );
endinterface

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - early-out restoring DIV/DIVU unit producing LO (quotient) and HI (remainder)
module div_iter_unit #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic      i_clk,
    input  logic      i_reset,
    div_iter_if.slave div_if
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_div0;
    logic [31:0] r_dividend;
    logic [31:0] r_dvs;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic [5:0]  r_cnt;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [5:0]  w_lz;
    logic [5:0]  w_n;
    logic [5:0]  w_shamt;
    logic [32:0] w_shift_r;
    logic [31:0] w_shift_q;
    logic [31:0] w_diff;
    logic        w_ge;

    assign w_dvd_mag = (div_if.is_signed && div_if.dividend[31]) ? -div_if.dividend : div_if.dividend;
    assign w_dvs_mag = (div_if.is_signed && div_if.divisor[31])  ? -div_if.divisor  : div_if.divisor;
    assign w_lz      = (div_if.lz_in > 32'd32) ? 6'd32 : div_if.lz_in[5:0];
    assign w_n       = EARLY_OUT ? (6'd32 - w_lz) : 6'd32;
    assign w_shamt   = 6'd32 - w_n;

    // 33-bit partial remainder so a divisor >= 2^31 never loses the carry-out bit
    assign w_shift_r = {r_r, r_q[31]};
    assign w_shift_q = {r_q[30:0], 1'b0};
    assign w_ge      = (w_shift_r >= {1'b0, r_dvs});
    assign w_diff    = w_shift_r[31:0] - r_dvs;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_div0      <= 1'b0;
            r_dividend  <= 32'd0;
            r_dvs       <= 32'd0;
            r_q         <= 32'd0;
            r_r         <= 32'd0;
            r_cnt       <= 6'd0;
            r_quotient  <= 32'd0;
            r_remainder <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (div_if.start) begin
                        r_sign_q   <= div_if.is_signed & (div_if.dividend[31] ^ div_if.divisor[31]);
                        r_sign_r   <= div_if.is_signed & div_if.dividend[31];
                        r_div0     <= (div_if.divisor == 32'd0);
                        r_dividend <= div_if.dividend;
                        r_dvs      <= w_dvs_mag;
                        r_q        <= w_dvd_mag << w_shamt;
                        r_r        <= 32'd0;
                        r_cnt      <= w_n;
                        r_busy     <= 1'b1;
                        r_state    <= (div_if.divisor == 32'd0 || w_n == 6'd0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_ge) begin
                        r_r <= w_diff;
                        r_q <= w_shift_q | 32'd1;
                    end else begin
                        r_r <= w_shift_r[31:0];
                        r_q <= w_shift_q;
                    end
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_div0) begin
                        r_quotient  <= 32'hFFFF_FFFF;
                        r_remainder <= r_dividend;
                    end else begin
                        r_quotient  <= r_sign_q ? -r_q : r_q;
                        r_remainder <= r_sign_r ? -r_r : r_r;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_if.quotient  = r_quotient;
    assign div_if.remainder = r_remainder;
    assign div_if.busy      = r_busy;
    assign div_if.done      = r_done;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - directed self-checking bench for div_iter_unit
module tb_div_iter_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    div_iter_if u_if ();

    div_iter_unit #(.EARLY_OUT(1'b1)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .div_if  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives start in the current cycle and returns in the cycle done is high.
    // Latency counts the start cycle as cycle 1.
    task automatic run_op(input logic sgn, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] lz, output int lat, output int busy_cyc,
                          input int mid_start_at);
        bit seen;
        u_if.start     = 1'b1;
        u_if.is_signed = sgn;
        u_if.dividend  = dvd;
        u_if.divisor   = dvs;
        u_if.lz_in     = lz;
        lat      = 1;
        busy_cyc = 0;
        seen     = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            u_if.start = 1'b0;
            if (mid_start_at != 0 && k == mid_start_at) begin
                u_if.start     = 1'b1;
                u_if.is_signed = 1'b0;
                u_if.dividend  = 32'd50;
                u_if.divisor   = 32'd3;
                u_if.lz_in     = 32'd26;
            end
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
            lat++;
            if (u_if.busy) busy_cyc++;
        end
        u_if.start = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] dvd,
                         input logic [31:0] dvs, input logic [31:0] lz,
                         input logic [31:0] exp_q, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        int bc;
        run_op(sgn, dvd, dvs, lz, lat, bc, 0);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_q"}, u_if.quotient, exp_q);
        check({tag, "_r"}, u_if.remainder, exp_r);
    endtask

    initial begin
        int lat;
        int bc;
        int done_cnt;
        n_cmp = 0;
        n_err = 0;
        reset          = 1'b1;
        u_if.start     = 1'b0;
        u_if.is_signed = 1'b0;
        u_if.dividend  = 32'd0;
        u_if.divisor   = 32'd0;
        u_if.lz_in     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, u_if.busy}, 32'd0);
        check("rst_done", {31'd0, u_if.done}, 32'd0);
        check("rst_q", u_if.quotient, 32'd0);
        check("rst_r", u_if.remainder, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(1'b0, 32'd100, 32'd7, 32'd25, lat, bc, 0);
        check("divu100_7_lat", lat, 9);
        check("divu100_7_busy", bc, 8);
        check("divu100_7_q", u_if.quotient, 32'd14);
        check("divu100_7_r", u_if.remainder, 32'd2);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, u_if.done}, 32'd0);
        check("hold_q", u_if.quotient, 32'd14);

        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd29, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd29, 32'hFFFF_FFFD, 32'd1, 5);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 34);
        do_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 34);
        do_op("divu_by0", 1'b0, 32'd1234, 32'd0, 32'd21, 32'hFFFF_FFFF, 32'd1234, 2);
        do_op("div_by0_neg", 1'b1, 32'hFFFF_FF00, 32'd0, 32'd24, 32'hFFFF_FFFF, 32'hFFFF_FF00, 2);
        do_op("divu_0_5", 1'b0, 32'd0, 32'd5, 32'd32, 32'd0, 32'd0, 2);
        do_op("divu_lz_clamp", 1'b0, 32'd0, 32'd5, 32'd40, 32'd0, 32'd0, 2);
        do_op("divu_big_dvs", 1'b0, 32'hF000_0000, 32'h8000_0001, 32'd0, 32'd1, 32'h6FFF_FFFF, 34);

        // Second start mid-CALC must be ignored
        run_op(1'b0, 32'd100, 32'd7, 32'd25, lat, bc, 3);
        check("midstart_lat", lat, 9);
        check("midstart_q", u_if.quotient, 32'd14);
        check("midstart_r", u_if.remainder, 32'd2);

        // Start accepted in the done cycle: 9/3, lz=28 -> N=4
        do_op("b2b", 1'b0, 32'd9, 32'd3, 32'd28, 32'd3, 32'd0, 6);

        // Reset three cycles into a 32-iteration op
        @(posedge clk);
        #1;
        u_if.start     = 1'b1;
        u_if.is_signed = 1'b0;
        u_if.dividend  = 32'h8000_0000;
        u_if.divisor   = 32'd1;
        u_if.lz_in     = 32'd0;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_busy", {31'd0, u_if.busy}, 32'd0);
        check("midrst_q", u_if.quotient, 32'd0);
        check("midrst_r", u_if.remainder, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (u_if.done) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", done_cnt, 0);
        do_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd25, 32'd14, 32'd2, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
